// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: credit-based fetch requests, in-flight PC tracking,
// stale-response filtering after redirects, and a small instruction buffer to decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus_4_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fpc_q, fpc_n;
    logic [CNT_W-1:0] outst_q, outst_n;
    logic [CNT_W-1:0] stale_q, stale_n;
    logic [CNT_W-1:0] fcnt_q, fcnt_n;
    logic [PTR_W-1:0] ipc_rd_q, ipc_rd_n, ipc_wr_q, ipc_wr_n;
    logic [PTR_W-1:0] f_rd_q, f_rd_n, f_wr_q, f_wr_n;
    logic             req_valid_q, req_valid_n;
    logic             instr_valid_q, instr_valid_n;
    logic [31:0]      instr_q, instr_n;
    logic [31:0]      pc_q, pc_n;
    logic [31:0]      pc4_q, pc4_n;

    logic [31:0] ipc_mem     [FIFO_DEPTH];
    logic [31:0] f_instr_mem [FIFO_DEPTH];
    logic [31:0] f_pc_mem    [FIFO_DEPTH];

    logic        req_accept;
    logic        rsp_drop;
    logic        fifo_push;
    logic        fifo_pop;
    logic [31:0] rsp_pc;

    // Low address bits of the redirect target are deliberately discarded.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign imem_req_valid_o = req_valid_q;
    assign imem_addr_o      = fpc_q;
    assign instr_valid_o    = instr_valid_q;
    assign instruction_o    = instr_q;
    assign pc_o             = pc_q;
    assign pc_plus_4_o      = pc4_q;

    // Next-state logic for fetch pointer, credit counters and instruction buffer.
    always_comb begin
        fpc_n         = fpc_q;
        stale_n       = stale_q;
        f_rd_n        = f_rd_q;
        f_wr_n        = f_wr_q;
        fcnt_n        = fcnt_q;

        req_accept = req_valid_q & imem_req_ready_i;
        // With an empty in-flight queue a response can only belong to this cycle's accept.
        rsp_pc     = (outst_q == '0) ? fpc_q : ipc_mem[ipc_rd_q];
        rsp_drop   = redirect_i | (stale_q != '0);
        fifo_push  = imem_rsp_valid_i & ~rsp_drop;
        fifo_pop   = instr_valid_q & instr_ready_i & ~redirect_i;

        outst_n  = outst_q + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid_i);
        ipc_wr_n = ipc_wr_q + PTR_W'(req_accept);
        ipc_rd_n = ipc_rd_q + PTR_W'(imem_rsp_valid_i);

        if (redirect_i) begin
            fpc_n = {redirect_pc_i[31:2], 2'b00};
        end else if (req_accept) begin
            fpc_n = fpc_q + 32'd4;
        end

        if (redirect_i) begin
            stale_n = outst_n;
        end else if (imem_rsp_valid_i && (stale_q != '0)) begin
            stale_n = stale_q - CNT_W'(1);
        end

        if (redirect_i) begin
            f_rd_n = '0;
            f_wr_n = '0;
            fcnt_n = '0;
        end else begin
            f_wr_n = f_wr_q + PTR_W'(fifo_push);
            f_rd_n = f_rd_q + PTR_W'(fifo_pop);
            fcnt_n = fcnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end

        // The new head is the entry being written when the read pointer lands on it.
        if (fifo_push && (f_rd_n == f_wr_q)) begin
            instr_n = imem_rsp_data_i;
            pc_n    = rsp_pc;
        end else begin
            instr_n = f_instr_mem[f_rd_n];
            pc_n    = f_pc_mem[f_rd_n];
        end
        pc4_n         = pc_n + 32'd4;
        instr_valid_n = (fcnt_n != '0);
        req_valid_n   = (SUM_W'(fcnt_n) + SUM_W'(outst_n)) < SUM_W'(FIFO_DEPTH);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q         <= RESET_PC;
            outst_q       <= '0;
            stale_q       <= '0;
            fcnt_q        <= '0;
            ipc_rd_q      <= '0;
            ipc_wr_q      <= '0;
            f_rd_q        <= '0;
            f_wr_q        <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            pc_q          <= 32'd0;
            pc4_q         <= 32'd4;
        end else begin
            fpc_q         <= fpc_n;
            outst_q       <= outst_n;
            stale_q       <= stale_n;
            fcnt_q        <= fcnt_n;
            ipc_rd_q      <= ipc_rd_n;
            ipc_wr_q      <= ipc_wr_n;
            f_rd_q        <= f_rd_n;
            f_wr_q        <= f_wr_n;
            req_valid_q   <= req_valid_n;
            instr_valid_q <= instr_valid_n;
            instr_q       <= instr_n;
            pc_q          <= pc_n;
            pc4_q         <= pc4_n;
        end
    end

    // Payload storage; validity is tracked entirely by the reset counters above.
    always_ff @(posedge clk) begin
        if (req_accept) begin
            ipc_mem[ipc_wr_q] <= fpc_q;
        end
        if (fifo_push) begin
            f_instr_mem[f_wr_q] <= imem_rsp_data_i;
            f_pc_mem[f_wr_q]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a random in-order memory and decode
// drive the DUT while a sequential-PC reference model predicts every delivered instruction.
module tb_instruction_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_4_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    instruction_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instruction_o    (instruction_o),
        .pc_o             (pc_o),
        .pc_plus_4_o      (pc_plus_4_o),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
        logic        stale;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] fetch_pc;
    int unsigned stale_pend;
    int unsigned arrived;
    bit          arr_inc_d;
    bit          redir_d;
    int unsigned cyc;
    int unsigned vectors;
    int unsigned errors;
    int unsigned pops;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        fetch_pc   = RST_PC;
        stale_pend = 0;
        arrived    = 0;
        arr_inc_d  = 1'b0;
        redir_d    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instruction", instruction_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_pc_plus_4", pc_plus_4_o, 32'd4);
    endtask

    // One clock cycle of memory, decode and redirect stimulus plus model bookkeeping.
    task automatic step(input int unsigned lat, input int unsigned p_rdy, input int unsigned p_mrdy,
                        input int unsigned p_redir, input bit force_redir, input logic [31:0] force_tgt);
        logic        acc;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        cyc++;
        if (redir_d) arrived = 0;
        else if (arr_inc_d) arrived = arrived + 1;
        arr_inc_d = 1'b0;
        redir_d   = 1'b0;

        check("req_valid_credit", 32'(imem_req_valid_o), 32'(exp_q.size() + stale_pend < DEPTH));

        imem_req_ready_i = ($urandom_range(99) < p_mrdy);
        instr_ready_i    = ($urandom_range(99) < p_rdy);
        redirect_i       = force_redir || ($urandom_range(99) < p_redir);
        if (force_redir) tgt = force_tgt;
        else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFE0 | 32'($urandom_range(31));
        else tgt = $urandom;
        redirect_pc_i = tgt;

        acc = imem_req_valid_o & imem_req_ready_i;
        if (acc) begin
            check("req_addr", imem_addr_o, fetch_pc);
            exp_q.push_back('{pc: fetch_pc, word: mem_word(fetch_pc)});
            pend_q.push_back('{addr: imem_addr_o, due: 32'(cyc + lat), stale: 1'b0});
            fetch_pc = fetch_pc + 32'd4;
        end

        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = $urandom;
        if (pend_q.size() != 0 && pend_q[0].due <= 32'(cyc)) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(pend_q[0].addr);
            if (pend_q[0].stale) stale_pend = stale_pend - 1;
            else if (!redirect_i) arr_inc_d = 1'b1;
            void'(pend_q.pop_front());
        end

        if (redirect_i) begin
            redir_d = 1'b1;
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            stale_pend = pend_q.size();
            fetch_pc   = {tgt[31:2], 2'b00};
        end
    endtask

    // Monitor: checks instruction availability and pops the scoreboard on each decode handshake.
    always @(negedge clk) begin
        if (reset) begin
            check("instr_valid", 32'(instr_valid_o), 32'(arrived != 0));
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL scoreboard_empty: got pc %h expected no instruction", pc_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pc", pc_o, e.pc);
                    check("instruction", instruction_o, e.word);
                    check("pc_plus_4", pc_plus_4_o, e.pc + 32'd4);
                    if (arrived != 0) arrived = arrived - 1;
                end
            end
        end
    end

    initial begin
        int unsigned pops_start;
        vectors = 0; errors = 0; pops = 0; cyc = 0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'd0;
        instr_ready_i    = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'd0;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #3 check_reset_outputs();
        reset = 1'b1;

        // Zero-wait memory, always-ready decode: one instruction per cycle from RESET_PC.
        repeat (5) step(0, 100, 100, 0, 1'b0, 32'd0);
        pops_start = pops;
        repeat (20) step(0, 100, 100, 0, 1'b0, 32'd0);
        check("throughput", pops - pops_start, 32'd20);

        // Decode stall: buffer fills, requests stop, nothing lost afterwards.
        repeat (12) step(0, 0, 100, 0, 1'b0, 32'd0);
        check("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("stall_instr_valid", 32'(instr_valid_o), 32'd1);
        repeat (8) step(0, 100, 100, 0, 1'b0, 32'd0);

        // Latency-3 memory with requests in flight, then redirect to an unaligned target.
        repeat (2) step(3, 100, 100, 0, 1'b0, 32'd0);
        step(3, 100, 100, 0, 1'b1, 32'h0040_0103);
        repeat (12) step(3, 100, 100, 0, 1'b0, 32'd0);

        // Redirect in a busy zero-wait cycle, to a target that wraps the address space.
        repeat (4) step(0, 100, 100, 0, 1'b0, 32'd0);
        step(0, 100, 100, 0, 1'b1, 32'hFFFF_FFF8);
        repeat (8) step(0, 100, 100, 0, 1'b0, 32'd0);

        // Random traffic with varying latency, back-pressure and redirects.
        for (int k = 0; k < 8; k++) begin
            int unsigned lat;
            lat = $urandom_range(3);
            repeat (50) step(lat, 70, 70, 5, 1'b0, 32'd0);
        end

        // Asynchronous reset mid-stream: outputs must clear without a clock edge.
        repeat (6) step(1, 100, 100, 0, 1'b0, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        imem_rsp_valid_i = 1'b0;
        redirect_i       = 1'b0;
        imem_req_ready_i = 1'b0;
        instr_ready_i    = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #3 model_reset();
        reset = 1'b1;

        repeat (6) step(0, 100, 100, 0, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            int unsigned lat;
            lat = $urandom_range(3);
            repeat (50) step(lat, 60, 80, 8, 1'b0, 32'd0);
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
